// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction ROM
// with one cycle of read latency, and hands {pc, inst} to decode under a
// valid/over/allow-in handshake. Single-cycle redirects from decode override
// any pending fetch.
module fetch_stage #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        ID_allow_in,
  input  logic [32:0] br_bus,
  output logic        IF_valid,
  output logic        IF_over,
  output logic [63:0] IF_ID_bus,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] count_q, count_d;
  logic        valid_q;

  logic        br_taken;
  logic [31:0] br_pc;
  logic        in_flight;
  logic        handoff;
  logic [31:0] inst_sel;

  // Redirect decode and handshake; IF_over never looks at ID_allow_in, so
  // there is no combinational path back into decode.
  always_comb begin
    br_taken  = br_bus[32] & valid_q;
    br_pc     = {br_bus[31:2], 2'b00};
    in_flight = (state_q == S_WAIT) || (state_q == S_HOLD);
    IF_over   = valid_q & in_flight & ~br_taken;
    handoff   = IF_over & ID_allow_in;
    case (state_q)
      S_WAIT:  inst_sel = inst_rdata;
      S_HOLD:  inst_sel = inst_buf_q;
      default: inst_sel = 32'h0;
    endcase
  end

  // Next-state: a redirect wins over everything, including a handoff.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    count_d    = count_q;
    if (br_taken) begin
      pc_d    = br_pc;
      state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ: state_d = S_WAIT;
        S_WAIT: begin
          if (handoff) begin
            pc_d    = pc_q + 32'd4;
            count_d = count_q + 32'd1;
            state_d = S_REQ;
          end else begin
            // ROM data is only valid this one cycle; capture it while stalled
            inst_buf_d = inst_rdata;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (handoff) begin
            pc_d    = pc_q + 32'd4;
            count_d = count_q + 32'd1;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State registers; an asynchronous reset discards any buffered instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= START_ADDR;
      inst_buf_q <= 32'h0;
      count_q    <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      count_q    <= count_d;
      valid_q    <= 1'b1;
    end
  end

  // Output taps.
  always_comb begin
    inst_addr   = pc_q;
    IF_valid    = valid_q;
    IF_ID_bus   = {pc_q, inst_sel};
    IF_pc       = pc_q;
    IF_inst     = inst_sel;
    fetch_count = count_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a ROM model feeds two instances (default start
// address and a start address at the top of memory); a scoreboard queue
// holds the expected {pc, inst} of every handoff of the main instance.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        ID_allow_in;
  logic [32:0] br_bus;

  logic [31:0] inst_addr, inst_rdata, IF_pc, IF_inst, fetch_count;
  logic        IF_valid, IF_over;
  logic [63:0] IF_ID_bus;

  logic [31:0] inst_addr2, inst_rdata2, IF_pc2, IF_inst2, fetch_count2;
  logic        IF_valid2, IF_over2;
  logic [63:0] IF_ID_bus2;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  fetch_stage #(.START_ADDR(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .ID_allow_in(ID_allow_in), .br_bus(br_bus), .IF_valid(IF_valid),
    .IF_over(IF_over), .IF_ID_bus(IF_ID_bus), .IF_pc(IF_pc),
    .IF_inst(IF_inst), .fetch_count(fetch_count)
  );

  fetch_stage #(.START_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .inst_addr(inst_addr2), .inst_rdata(inst_rdata2),
    .ID_allow_in(ID_allow_in), .br_bus(33'h0), .IF_valid(IF_valid2),
    .IF_over(IF_over2), .IF_ID_bus(IF_ID_bus2), .IF_pc(IF_pc2),
    .IF_inst(IF_inst2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h2000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous ROMs, one cycle of read latency
  always @(posedge clk) begin
    inst_rdata  <= rom_word(inst_addr);
    inst_rdata2 <= rom_word(inst_addr2);
  end

  // Handoff monitor for the main instance
  always @(negedge clk) begin
    if (!reset && IF_over && ID_allow_in) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL handoff_unexpected: got %h, expected no handoff", IF_ID_bus);
      end else begin
        logic [63:0] exp_v;
        exp_v = sb.pop_front();
        if (IF_ID_bus !== exp_v) begin
          errors++;
          $display("FAIL handoff_data: got %h, expected %h", IF_ID_bus, exp_v);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    sb.push_back({pc, rom_word(pc)});
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp_v);
    end
  endtask

  // Returns one tick after release; the next rising edge is the first live one
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    br_bus = 33'h0;
    repeat (3) cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    ID_allow_in = 1'b1;
    br_bus      = 33'h0;
    #100;
    chk("rst_inst_addr", 64'(inst_addr), 64'h0);
    chk("rst_valid", 64'(IF_valid), 64'd0);
    chk("rst_over", 64'(IF_over), 64'd0);
    chk("rst_bus", IF_ID_bus, 64'h0);
    chk("rst_inst", 64'(IF_inst), 64'h0);
    chk("rst_count", 64'(fetch_count), 64'h0);
    chk("rst_wrap_addr", 64'(inst_addr2), 64'hFFFF_FFFC);
    chk("rst_wrap_bus", IF_ID_bus2, {32'hFFFF_FFFC, 32'h0});
  endtask

  task automatic test_fetch();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    #1;
    reset = 1'b0;
    cyc();
    chk("valid_after_release", 64'(IF_valid), 64'd1);
    repeat (4) cyc();
    @(negedge clk);
    chk("fetch_count_2", 64'(fetch_count), 64'd2);
    chk("fetch_wait_pc8", 64'(IF_pc), 64'h8);
    cyc();
    ID_allow_in = 1'b0;
    @(negedge clk);
    chk("fetch_count_3", 64'(fetch_count), 64'd3);
    chk("fetch_next_addr", 64'(inst_addr), 64'hC);
    chk("fetch_req_over", 64'(IF_over), 64'd0);
  endtask

  task automatic test_backpressure();
    do_reset();
    ID_allow_in = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    repeat (5) cyc();
    ID_allow_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bus_held", IF_ID_bus, {32'h8, 32'h2000_0002});
      chk("bp_over", 64'(IF_over), 64'd1);
      cyc();
    end
    ID_allow_in = 1'b1;
    cyc();
    @(negedge clk);
    chk("bp_next_addr", 64'(inst_addr), 64'hC);
    chk("bp_count_once", 64'(fetch_count), 64'd3);
    cyc();
    cyc();
    ID_allow_in = 1'b0;
    @(negedge clk);
    chk("bp_count_after", 64'(fetch_count), 64'd4);
  endtask

  task automatic test_redirect_wait();
    do_reset();
    ID_allow_in = 1'b1;
    br_bus = {1'b1, 32'h0000_0100};
    push_exp(32'h0);
    cyc();
    br_bus = 33'h0;
    @(negedge clk);
    chk("br_invalid_ignored_pc", 64'(IF_pc), 64'h0);
    chk("br_invalid_over", 64'(IF_over), 64'd1);
    cyc();
    cyc();
    br_bus = {1'b1, 32'h0000_0041};
    @(negedge clk);
    chk("brw_over", 64'(IF_over), 64'd0);
    chk("brw_count", 64'(fetch_count), 64'd1);
    push_exp(32'h40);
    cyc();
    br_bus = 33'h0;
    @(negedge clk);
    chk("brw_target_addr", 64'(inst_addr), 64'h40);
    chk("brw_count_kept", 64'(fetch_count), 64'd1);
    cyc();
    cyc();
    ID_allow_in = 1'b0;
    @(negedge clk);
    chk("brw_count_after", 64'(fetch_count), 64'd2);
    chk("brw_pc_after", 64'(IF_pc), 64'h44);
  endtask

  task automatic test_redirect_hold();
    do_reset();
    ID_allow_in = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("brh_hold_bus", IF_ID_bus, {32'h0, 32'h2000_0000});
    cyc();
    br_bus      = {1'b1, 32'h0000_0080};
    ID_allow_in = 1'b1;
    @(negedge clk);
    chk("brh_over_killed", 64'(IF_over), 64'd0);
    push_exp(32'h80);
    cyc();
    br_bus = 33'h0;
    @(negedge clk);
    chk("brh_target_addr", 64'(inst_addr), 64'h80);
    chk("brh_count", 64'(fetch_count), 64'd0);
    cyc();
    cyc();
    ID_allow_in = 1'b0;
    @(negedge clk);
    chk("brh_count_after", 64'(fetch_count), 64'd1);
  endtask

  task automatic test_pc_wrap();
    do_reset();
    ID_allow_in = 1'b1;
    push_exp(32'h0); push_exp(32'h4);
    cyc();
    @(negedge clk);
    chk("wrap_bus_top", IF_ID_bus2, {32'hFFFF_FFFC, 32'h5FFF_FFFF});
    chk("wrap_over_top", 64'(IF_over2), 64'd1);
    cyc();
    @(negedge clk);
    chk("wrap_addr_zero", 64'(inst_addr2), 64'h0);
    chk("wrap_count_1", 64'(fetch_count2), 64'd1);
    cyc();
    @(negedge clk);
    chk("wrap_bus_zero", IF_ID_bus2, {32'h0, 32'h2000_0000});
    cyc();
    ID_allow_in = 1'b0;
    @(negedge clk);
    chk("wrap_count_2", 64'(fetch_count2), 64'd2);
  endtask

  task automatic test_async_reset();
    do_reset();
    ID_allow_in = 1'b1;
    push_exp(32'h0);
    cyc();
    cyc();
    ID_allow_in = 1'b0;
    cyc();
    cyc();
    chk("ar_hold_over", 64'(IF_over), 64'd1);
    chk("ar_hold_pc", 64'(IF_pc), 64'h4);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(IF_valid), 64'd0);
    chk("ar_over", 64'(IF_over), 64'd0);
    chk("ar_addr", 64'(inst_addr), 64'h0);
    chk("ar_bus", IF_ID_bus, 64'h0);
    chk("ar_count", 64'(fetch_count), 64'h0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    ID_allow_in = 1'b1;
    push_exp(32'h0);
    cyc();
    cyc();
    ID_allow_in = 1'b0;
    @(negedge clk);
    chk("ar_restart_count", 64'(fetch_count), 64'd1);
    chk("ar_restart_pc", 64'(IF_pc), 64'h4);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_pc_wrap();
    test_async_reset();
    repeat (2) cyc();
    chk("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the five-stage pipelined CPU; sits directly upstream of the decode (ID) stage.
- Owns the PC and drives the synchronous instruction ROM (1-cycle read latency).
- Packs {pc, inst} onto the 64-bit IF→ID bus under a valid/over/allow-in handshake.
- Accepts single-cycle branch/jump redirects from ID; exports debug taps for the top-level display.

Parameters:
START_ADDR, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
inst_addr  out  32  instruction ROM address (word-aligned byte address)
inst_rdata  in  32  ROM data, valid the cycle after inst_addr was sampled
ID_allow_in  in  1  ID can accept a new instruction this cycle
br_bus  in  33  {br_taken[32], br_target[31:0]}; br_taken is a 1-cycle pulse
IF_valid  out  1  stage holds live state (0 in reset)
IF_over  out  1  instruction on IF_ID_bus is complete and not cancelled
IF_ID_bus  out  64  {pc[63:32], inst[31:0]}
IF_pc  out  32  current fetch PC (debug)
IF_inst  out  32  instruction currently presented (debug)
fetch_count  out  32  number of instructions handed to ID

Behaviour:
- Reset (async, high): pc=START_ADDR, state=S_REQ, IF_valid=0, inst_buf=0, fetch_count=0. Outputs during reset: inst_addr=START_ADDR, IF_over=0, IF_ID_bus={START_ADDR,32'h0}, IF_inst=0.
- IF_valid: set to 1 on the first rising edge after reset deasserts; stays 1 until the next reset.
- inst_addr = pc in all states. The ROM samples it each edge.
- States: S_REQ, S_WAIT, S_HOLD; 2-bit encoding.
- S_REQ:
  - Address presented.
  - Next state is S_WAIT, unless br_taken.
- S_WAIT:
  - inst_rdata is valid. IF_over=1, IF_ID_bus={pc, inst_rdata}.
  - If handoff (IF_over & ID_allow_in): pc<=pc+4, fetch_count++, go to S_REQ.
  - Else: inst_buf<=inst_rdata, go to S_HOLD.
- S_HOLD:
  - IF_over=1, IF_ID_bus={pc, inst_buf}. The bus is stable while held.
  - On handoff: pc<=pc+4, fetch_count++, go to S_REQ.
- Handoff definition: handoff = IF_over & ID_allow_in & IF_valid.
- Redirect (br_taken=1, any state):
  - pc <= {br_target[31:2],2'b00}. The low two bits are forced to zero.
  - Next state is S_REQ. The current or in-flight instruction is cancelled.
  - IF_over is forced to 0 in that cycle, so no handoff occurs and fetch_count does not change.
  - Redirect has priority over a simultaneous handoff. There is no delay slot.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- Throughput: with ID_allow_in held 1, one instruction every 2 cycles. Handoffs occur in S_WAIT cycles only.
- br_taken while IF_valid=0 is ignored.
- Reset asserted mid-operation (any state) returns immediately to reset values. A buffered instruction is discarded.
- IF_pc = pc; IF_inst = IF_ID_bus[31:0].
- Combinational outputs (IF_over, IF_ID_bus) must not depend on ID_allow_in, so there is no combinational loop with ID.

Test Plan:
1. Reset held 100 ns, ROM word n = 32'h2000_0000+n, ID_allow_in=1 → first handoff {0x0000_0000, 0x2000_0000}. Then pc 0x4, 0x8 handed every 2 cycles. fetch_count=3 after the third handoff.
2. Backpressure: ID_allow_in=0 for 5 cycles while in S_WAIT at pc=0x8 → state S_HOLD, IF_ID_bus held at {0x8, 0x2000_0002} all 5 cycles with IF_over=1. Then ID_allow_in=1 → exactly one handoff, next inst_addr=0xC.
3. Redirect in S_WAIT coincident with ID_allow_in=1, br_target=0x0000_0041 → no handoff, fetch_count unchanged. Next inst_addr=0x40, next handoff pc=0x40.
4. Redirect during S_HOLD → buffered instruction dropped, IF_over=0 that cycle. Fetch resumes at target.
5. PC wrap: START_ADDR=32'hFFFF_FFFC → handoffs at pc 0xFFFF_FFFC then 0x0000_0000.
6. Async reset asserted mid-cycle in S_HOLD → outputs reach reset values before the next clk edge. Fetch restarts at START_ADDR after release.
